// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_if
// Brief    : Zicsr access port between the execute stage and csr_file.
// Revision : 1.0  initial release
// ============================================================================
interface csr_file_if;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        illegal_csr_o;

  modport master (
    output csr_raddr_i, csr_op_i, csr_waddr_i, csr_wdata_i,
    input  csr_rdata_o, illegal_csr_o
  );

  modport slave (
    input  csr_raddr_i, csr_op_i, csr_waddr_i, csr_wdata_i,
    output csr_rdata_o, illegal_csr_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : RV32I machine-mode CSR file with trap/mret side effects and
//            optional 64-bit mcycle/minstret counters (macro CSR_COUNTERS_EN).
// Revision : 1.0  initial release
// ============================================================================
module csr_file (
  input  wire logic        clk,
  input  wire logic        rst_n,
  csr_file_if.slave        csr_bus,
  input  wire logic        set_mepc_i,
  input  wire logic [31:0] epc_i,
  input  wire logic        set_mcause_i,
  input  wire logic        ie_type_i,
  input  wire logic [3:0]  exception_code_i,
  input  wire logic        set_mtval_i,
  input  wire logic [31:0] mtval_i,
  input  wire logic        ecall_en_i,
  input  wire logic        mret_en_i,
  input  wire logic        instret_i,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      mepc_o,
  output logic             mie_o
);

  localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] c_ADDR_MISA      = 12'h301;
  localparam logic [11:0] c_ADDR_MIE       = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] c_ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] c_ADDR_MIP       = 12'h344;
  localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] c_MISA_VALUE     = 32'h4000_0100;

  localparam logic [1:0]  c_OP_NONE  = 2'b00;
  localparam logic [1:0]  c_OP_WRITE = 2'b01;
  localparam logic [1:0]  c_OP_SET   = 2'b10;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
`endif

  logic [31:0] w_mstatus;
  logic [31:0] w_old;
  logic [31:0] w_wval;
  logic        w_access;
  logic        w_writable;
  logic        w_flush;
  logic        w_wen;
  logic        w_unused;

  // MPP is hardwired to M-mode; only MIE and MPIE are stored.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  function automatic logic [31:0] read_csr(input logic [11:0] addr);
    logic [31:0] v;
    v = '0;
    case (addr)
      c_ADDR_MSTATUS:   v = w_mstatus;
      c_ADDR_MISA:      v = c_MISA_VALUE;
      c_ADDR_MIE:       v = r_mie;
      c_ADDR_MTVEC:     v = r_mtvec;
      c_ADDR_MSCRATCH:  v = r_mscratch;
      c_ADDR_MEPC:      v = r_mepc;
      c_ADDR_MCAUSE:    v = r_mcause;
      c_ADDR_MTVAL:     v = r_mtval;
`ifdef CSR_COUNTERS_EN
      c_ADDR_MCYCLE:    v = r_mcycle[31:0];
      c_ADDR_MCYCLEH:   v = r_mcycle[63:32];
      c_ADDR_MINSTRET:  v = r_minstret[31:0];
      c_ADDR_MINSTRETH: v = r_minstret[63:32];
`endif
      default:          v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_writable(input logic [11:0] addr);
    logic w;
    w = 1'b0;
    case (addr)
      c_ADDR_MSTATUS, c_ADDR_MIE, c_ADDR_MTVEC, c_ADDR_MSCRATCH,
      c_ADDR_MEPC, c_ADDR_MCAUSE, c_ADDR_MTVAL: w = 1'b1;
`ifdef CSR_COUNTERS_EN
      c_ADDR_MCYCLE, c_ADDR_MCYCLEH,
      c_ADDR_MINSTRET, c_ADDR_MINSTRETH:        w = 1'b1;
`endif
      default:                                  w = 1'b0;
    endcase
    return w;
  endfunction

  always_comb begin
    csr_bus.csr_rdata_o = read_csr(csr_bus.csr_raddr_i);
    w_old               = read_csr(csr_bus.csr_waddr_i);
    w_writable          = is_writable(csr_bus.csr_waddr_i);
    case (csr_bus.csr_op_i)
      c_OP_WRITE: w_wval = csr_bus.csr_wdata_i;
      c_OP_SET:   w_wval = w_old | csr_bus.csr_wdata_i;
      default:    w_wval = w_old & ~csr_bus.csr_wdata_i;
    endcase
  end

  assign w_access              = (csr_bus.csr_op_i != c_OP_NONE);
  assign csr_bus.illegal_csr_o = w_access && !w_writable;
  // A trapping or returning instruction is flushed, so its CSR write must not land.
  assign w_flush = ecall_en_i | mret_en_i | set_mepc_i | set_mcause_i | set_mtval_i;
  assign w_wen   = w_access && w_writable && !w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      if (ecall_en_i) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_en_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MSTATUS) begin
        r_mstatus_mie  <= w_wval[3];
        r_mstatus_mpie <= w_wval[7];
      end

      if (set_mepc_i) begin
        r_mepc <= {epc_i[31:2], 2'b00};
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MEPC) begin
        r_mepc <= {w_wval[31:2], 2'b00};
      end

      if (set_mcause_i) begin
        r_mcause <= {ie_type_i, 27'b0, exception_code_i};
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MCAUSE) begin
        r_mcause <= w_wval;
      end

      if (set_mtval_i) begin
        r_mtval <= mtval_i;
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MTVAL) begin
        r_mtval <= w_wval;
      end

      if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MTVEC) begin
        r_mtvec <= {w_wval[31:2], 1'b0, w_wval[0]};
      end
      if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MSCRATCH) begin
        r_mscratch <= w_wval;
      end
      if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MIE) begin
        r_mie <= w_wval;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A software write to either half replaces that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MCYCLE) begin
        r_mcycle[31:0] <= w_wval;
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MCYCLEH) begin
        r_mcycle[63:32] <= w_wval;
      end else begin
        r_mcycle <= r_mcycle + 64'd1;
      end

      if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MINSTRET) begin
        r_minstret[31:0] <= w_wval;
      end else if (w_wen && csr_bus.csr_waddr_i == c_ADDR_MINSTRETH) begin
        r_minstret[63:32] <= w_wval;
      end else if (instret_i) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end

  assign w_unused = ^epc_i[1:0];
`else
  assign w_unused = ^{epc_i[1:0], instret_i};
`endif

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mstatus_mie;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Scoreboard-based self-checking bench for csr_file.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic        set_mepc_i;
  logic [31:0] epc_i;
  logic        set_mcause_i;
  logic        ie_type_i;
  logic [3:0]  exception_code_i;
  logic        set_mtval_i;
  logic [31:0] mtval_i;
  logic        ecall_en_i;
  logic        mret_en_i;
  logic        instret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  csr_file_if bus ();

  csr_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_bus          (bus.slave),
    .set_mepc_i       (set_mepc_i),
    .epc_i            (epc_i),
    .set_mcause_i     (set_mcause_i),
    .ie_type_i        (ie_type_i),
    .exception_code_i (exception_code_i),
    .set_mtval_i      (set_mtval_i),
    .mtval_i          (mtval_i),
    .ecall_en_i       (ecall_en_i),
    .mret_en_i        (mret_en_i),
    .instret_i        (instret_i),
    .mtvec_o          (mtvec_o),
    .mepc_o           (mepc_o),
    .mie_o            (mie_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic expect_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop_check(obs);
  endtask

  task automatic expect_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_raddr_i = addr;
    sb_push(tag, exp);
    #1;
    sb_pop_check(bus.csr_rdata_o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] data, input logic exp_ill);
    bus.csr_op_i    = op;
    bus.csr_waddr_i = addr;
    bus.csr_wdata_i = data;
    #1;
    expect_sig(tag, {31'b0, bus.illegal_csr_o}, {31'b0, exp_ill});
    tick();
    bus.csr_op_i = 2'b00;
  endtask

  task automatic clear_ctrl();
    set_mepc_i   = 1'b0;
    set_mcause_i = 1'b0;
    set_mtval_i  = 1'b0;
    ecall_en_i   = 1'b0;
    mret_en_i    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_ctrl();
    epc_i = '0; ie_type_i = 1'b0; exception_code_i = '0; mtval_i = '0; instret_i = 1'b0;
    bus.csr_raddr_i = '0; bus.csr_op_i = '0; bus.csr_waddr_i = '0; bus.csr_wdata_i = '0;

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    expect_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    expect_sig("rst_mtvec_o", mtvec_o, 32'h0);
    expect_sig("rst_mepc_o", mepc_o, 32'h0);
    expect_sig("rst_mie_o", {31'b0, mie_o}, 32'h0);
    #6 rst_n = 1'b1;
    tick();

    csr_wr("ill_mtvec_wr", 2'b01, 12'h305, 32'h8000_0103, 1'b0);
    expect_sig("mtvec_o", mtvec_o, 32'h8000_0101);
    expect_rd("mtvec_rd", 12'h305, 32'h8000_0101);
    csr_wr("ill_mstatus_set", 2'b10, 12'h300, 32'h0000_0008, 1'b0);
    expect_rd("mstatus_set", 12'h300, 32'h0000_1808);
    expect_sig("mie_o_set", {31'b0, mie_o}, 32'h1);

    // Trap entry with a concurrent software write to mscratch that must be dropped
    set_mepc_i = 1'b1; epc_i = 32'h0000_0106;
    set_mcause_i = 1'b1; ie_type_i = 1'b0; exception_code_i = 4'hB;
    set_mtval_i = 1'b1; mtval_i = 32'h0;
    ecall_en_i = 1'b1;
    bus.csr_op_i = 2'b01; bus.csr_waddr_i = 12'h340; bus.csr_wdata_i = 32'hDEAD_BEEF;
    #1;
    expect_sig("trap_mtvec_stable", mtvec_o, 32'h8000_0101);
    tick();
    clear_ctrl();
    bus.csr_op_i = 2'b00;
    expect_rd("trap_mepc", 12'h341, 32'h0000_0104);
    expect_sig("trap_mepc_o", mepc_o, 32'h0000_0104);
    expect_rd("trap_mcause", 12'h342, 32'h0000_000B);
    expect_rd("trap_mstatus", 12'h300, 32'h0000_1880);
    expect_sig("trap_mie_o", {31'b0, mie_o}, 32'h0);
    expect_rd("trap_mscratch_kept", 12'h340, 32'h0);
    mret_en_i = 1'b1;
    tick();
    clear_ctrl();
    expect_rd("mret_mstatus", 12'h300, 32'h0000_1888);
    expect_sig("mret_mie_o", {31'b0, mie_o}, 32'h1);

    // Trap capture beats a same-cycle software mepc write
    bus.csr_op_i = 2'b01; bus.csr_waddr_i = 12'h341; bus.csr_wdata_i = 32'h1234_5678;
    set_mepc_i = 1'b1; epc_i = 32'h0000_0040;
    tick();
    clear_ctrl();
    bus.csr_op_i = 2'b00;
    expect_rd("mepc_prio", 12'h341, 32'h0000_0040);
    csr_wr("ill_mepc_wr", 2'b01, 12'h341, 32'h0000_1003, 1'b0);
    expect_rd("mepc_align", 12'h341, 32'h0000_1000);

    // ecall and mret together: trap entry only
    ecall_en_i = 1'b1; mret_en_i = 1'b1;
    tick();
    clear_ctrl();
    expect_rd("both_mstatus", 12'h300, 32'h0000_1880);
    csr_wr("ill_mstatus_w0", 2'b01, 12'h300, 32'h0, 1'b0);
    expect_rd("mstatus_zero", 12'h300, 32'h0000_1800);
    csr_wr("ill_mstatus_w1", 2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0);
    expect_rd("mstatus_mask", 12'h300, 32'h0000_1888);

    csr_wr("ill_mscratch_w", 2'b01, 12'h340, 32'hF0F0_F0F0, 1'b0);
    csr_wr("ill_mscratch_s", 2'b10, 12'h340, 32'h0F00_0000, 1'b0);
    expect_rd("mscratch_set", 12'h340, 32'hFFF0_F0F0);
    csr_wr("ill_mscratch_c", 2'b11, 12'h340, 32'h0000_00F0, 1'b0);
    expect_rd("mscratch_clr", 12'h340, 32'hFFF0_F000);
    csr_wr("ill_mcause_w", 2'b01, 12'h342, 32'hA5A5_5A5A, 1'b0);
    expect_rd("mcause_full", 12'h342, 32'hA5A5_5A5A);
    csr_wr("ill_mie_w", 2'b01, 12'h304, 32'h0000_0888, 1'b0);
    expect_rd("mie_reg", 12'h304, 32'h0000_0888);

    // set_mtval alone also flushes a software write
    set_mtval_i = 1'b1; mtval_i = 32'h0000_0055;
    bus.csr_op_i = 2'b01; bus.csr_waddr_i = 12'h340; bus.csr_wdata_i = 32'h0000_AAAA;
    tick();
    clear_ctrl();
    bus.csr_op_i = 2'b00;
    expect_rd("mtval_trap", 12'h343, 32'h0000_0055);
    expect_rd("mscratch_flushed", 12'h340, 32'hFFF0_F000);

    // Read-only and unimplemented addresses
    csr_wr("ill_mhartid", 2'b01, 12'hF14, 32'hFFFF_FFFF, 1'b1);
    expect_rd("mhartid_rd", 12'hF14, 32'h0);
    csr_wr("ill_misa", 2'b10, 12'h301, 32'hFFFF_FFFF, 1'b1);
    expect_rd("misa_rd", 12'h301, 32'h4000_0100);
    csr_wr("ill_mip", 2'b01, 12'h344, 32'hFFFF_FFFF, 1'b1);
    expect_rd("mip_rd", 12'h344, 32'h0);
    csr_wr("ill_unimpl", 2'b11, 12'h7C0, 32'h1, 1'b1);
    expect_rd("unimpl_rd", 12'h7C0, 32'h0);
    csr_wr("ill_op_none", 2'b00, 12'h7C0, 32'h1, 1'b0);

`ifdef CSR_COUNTERS_EN
    csr_wr("ill_mcycle_w", 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    csr_wr("ill_mcycleh_w", 2'b01, 12'hB80, 32'h0, 1'b0);
    tick();
    tick();
    bus.csr_raddr_i = 12'hB80;
    #1;
    expect_sig("mcycleh_carry", bus.csr_rdata_o, 32'h1);
    expect_rd("mcycle_wrap", 12'hB00, 32'h1);
    csr_wr("ill_minstret_w", 2'b01, 12'hB02, 32'h5, 1'b0);
    instret_i = 1'b1;
    tick(); tick(); tick();
    instret_i = 1'b0;
    tick();
    expect_rd("minstret_cnt", 12'hB02, 32'h8);
    expect_rd("minstreth_cnt", 12'hB82, 32'h0);
`else
    expect_rd("mcycle_absent", 12'hB00, 32'h0);
    expect_rd("minstreth_absent", 12'hB82, 32'h0);
    csr_wr("ill_mcycle_absent", 2'b01, 12'hB00, 32'h1, 1'b1);
    csr_wr("ill_minstret_absent", 2'b10, 12'hB02, 32'h1, 1'b1);
`endif

    // Reset asserted mid-operation clears state without a clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_sig("mid_rst_mtvec_o", mtvec_o, 32'h0);
    expect_sig("mid_rst_mepc_o", mepc_o, 32'h0);
    expect_sig("mid_rst_mie_o", {31'b0, mie_o}, 32'h0);
    expect_rd("mid_rst_mstatus", 12'h300, 32'h0000_1800);
    expect_rd("mid_rst_mscratch", 12'h340, 32'h0);
    rst_n = 1'b1;
    tick();

    if (exp_q.size() != 0) check_val("scoreboard_leftover", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the RV32I core, sitting directly downstream of the exception controller. It holds mstatus, mtvec, mepc, mcause, mtval, mscratch and the cycle/instret counters. It applies trap-entry and mret side effects from the exception controller, and serves Zicsr read/modify/write accesses from the execute stage. It feeds `mtvec` and `mepc` back to the exception controller for trap-vector and return-PC generation.

## Interface
- No parameters; data width is `REG_BUS` (32 bits).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `csr_raddr_i` in 12: CSR read address.
- `csr_rdata_o` out 32: combinational read data.
- `csr_op_i` in 2: access operation. 00 none, 01 write, 10 set, 11 clear.
- `csr_waddr_i` in 12: CSR write address.
- `csr_wdata_i` in 32: operand (rs1 value or zimm).
- `illegal_csr_o` out 1: combinational. High when `csr_op_i`≠00 and the address is unimplemented or read-only.
- `set_mepc_i` in 1, `epc_i` in 32: capture trap PC into mepc.
- `set_mcause_i` in 1, `ie_type_i` in 1, `exception_code_i` in 4: capture the trap cause.
- `set_mtval_i` in 1, `mtval_i` in 32: capture the trap value.
- `ecall_en_i` in 1: trap entry; updates the mstatus stack.
- `mret_en_i` in 1: trap return; pops the mstatus stack.
- `instret_i` in 1: one instruction retired this cycle.
- `mtvec_o` out 32, `mepc_o` out 32, `mie_o` out 1: registered CSR views.

## Operation
- Address map:
  - 0x300 mstatus; 0x301 misa (RO, 32'h4000_0100); 0x304 mie; 0x305 mtvec.
  - 0x340 mscratch; 0x341 mepc; 0x342 mcause; 0x343 mtval; 0x344 mip (RO, 0).
  - 0xB00/0xB80 mcycle/mcycleh; 0xB02/0xB82 minstret/minstreth; 0xF14 mhartid (RO, 0).
  - Any other address reads 0.
- Write value by op: write→wdata; set→old|wdata; clear→old&~wdata. "old" is the current register value.
- Writes to RO or unimplemented addresses are dropped and raise `illegal_csr_o`.
- Field masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired 2'b11; all other bits read 0.
  - mtvec: bit[1] is forced to 0.
  - mepc: bits[1:0] are forced to 0, on both software and trap writes.
  - mcause is fully writable.
- Trap capture, each independent:
  - `set_mepc_i`: mepc←{epc_i[31:2],2'b00}.
  - `set_mcause_i`: mcause←{ie_type_i,27'b0,exception_code_i}.
  - `set_mtval_i`: mtval←mtval_i.
- `ecall_en_i`: MPIE←MIE, MIE←0.
- `mret_en_i`: MIE←MPIE, MPIE←1.
- Priority, same cycle:
  - trap entry > mret > CSR software write.
  - Any of `ecall_en_i`/`mret_en_i`/`set_*_i` asserted suppresses the software write in that cycle, because the instruction is flushed.
  - `ecall_en_i` and `mret_en_i` both high: only trap entry applies.
- Counters:
  - mcycle (64-bit) increments every cycle out of reset.
  - minstret (64-bit) increments when `instret_i` is high.
  - Low-word overflow from 32'hFFFF_FFFF carries into the high word; the full 64-bit wrap is to 0.
  - A software write to either half wins over the increment in that cycle; the other half is unchanged.
- Reset values:
  - mstatus 32'h0000_1800; mtvec 32'h0000_0000.
  - mepc, mcause, mtval, mscratch, mie, counters all 0.
  - `mtvec_o`=0, `mepc_o`=0, `mie_o`=0.
  - Reset assertion mid-operation clears all state immediately, without waiting for `clk`.

## Timing
- Reads are combinational from current state; there is no read-after-write bypass.
- A write at edge N is visible on `csr_rdata_o` and the `_o` views after edge N.
- Trap/mret updates land at the same edge the control inputs are sampled. `mtvec_o` and `mepc_o` are stable in that cycle, so the exception controller's `new_pc_o` uses pre-update values.
- `illegal_csr_o` has zero latency; the register write is gated in the same cycle.

## Configuration
- `CSR_COUNTERS_EN` defined: mcycle/mcycleh/minstret/minstreth are implemented as above.
- `CSR_COUNTERS_EN` undefined: the counter registers are absent, 0xB00/0xB80/0xB02/0xB82 read 0, writes raise `illegal_csr_o`, and `instret_i` is ignored.

## Test plan
- Reset with `rst_n`=0 mid-cycle, no clock edge: mstatus reads 32'h0000_1800, mtvec_o=0, mepc_o=0, mie_o=0 immediately.
- Write 0x305 with 32'h8000_0103, then set 0x300 with 32'h8: mtvec_o=32'h8000_0101; mstatus=32'h0000_1808; mie_o=1.
- MIE=1, then pulse set_mepc/set_mcause/set_mtval/ecall_en with epc_i=32'h0000_0106, code 4'hB, mtval_i=32'h0 → mepc=32'h0000_0104, mcause=32'h0000_000B, mstatus=32'h0000_1880. Next cycle pulse mret_en → mstatus=32'h0000_1888.
- Same cycle: csr_op=01 to 0x341 with 32'h1234_5678 and set_mepc_i with epc_i=32'h40 → mepc=32'h40.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 → two cycles later mcycleh=1, mcycle=1. Write to 0xF14 → illegal_csr_o=1, mhartid still 0.
- With `CSR_COUNTERS_EN` undefined: read 0xB00 → 0; write 0xB00 → illegal_csr_o=1.
